div_hilo_seq: RTL and testbench

- Sequencing stage wrapped around the combinational 32-bit signed divider.
- Accepts a divide request from the control unit and registers the operands that drive the divider.
- Holds the divider inputs stable for a fixed multicycle settle window, then applies the signed-remainder fix and captures quotient into LO and remainder into HI.
- Also serves mfhi/mflo reads and mthi/mtlo writes for the datapath.

---
 rtl/div_hilo_seq.sv | 150 +++++++++++++++
 tb/tb_div_hilo_seq.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/div_hilo_seq.sv
// div_hilo_seq: sequencing stage around a combinational 32-bit signed divider.
// Registers the divide operands, holds them for SETTLE_CYCLES edges, then
// captures quotient into LO and the sign-corrected remainder into HI. Also
// serves mthi/mtlo writes while idle.
//
// Ports:
//   clock, clear                   rising-edge clock, async active-high reset
//   start, dividend_in, divisor_in divide request and signed operands
//   hi_wr/hi_in, lo_wr/lo_in       mthi/mtlo write strobes and data
//   div_dividend, div_divisor      registered operands driven to the divider
//   div_quotient, div_remainder    divider results (remainder is a magnitude)
//   busy, done, div_zero           stall, one-cycle completion pulse, sticky /0
//   hi_out, lo_out                 HI and LO registers
//
// SETTLE_CYCLES must lie in 1..15 (4-bit counter).
module div_hilo_seq #(
    parameter int unsigned SETTLE_CYCLES = 4
) (
    input  logic        clock,
    input  logic        clear,
    input  logic        start,
    input  logic [31:0] dividend_in,
    input  logic [31:0] divisor_in,
    input  logic        hi_wr,
    input  logic        lo_wr,
    input  logic [31:0] hi_in,
    input  logic [31:0] lo_in,
    output logic [31:0] div_dividend,
    output logic [31:0] div_divisor,
    input  logic [31:0] div_quotient,
    input  logic [31:0] div_remainder,
    output logic        busy,
    output logic        done,
    output logic        div_zero,
    output logic [31:0] hi_out,
    output logic [31:0] lo_out
);

    localparam int unsigned CNT_W  = 4;
    localparam int unsigned DATA_W = 32;

    typedef enum logic {
        S_IDLE   = 1'b0,
        S_SETTLE = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [DATA_W-1:0]   dividend_q, dividend_d;
    logic [DATA_W-1:0]   divisor_q, divisor_d;
    logic [DATA_W-1:0]   hi_q, hi_d;
    logic [DATA_W-1:0]   lo_q, lo_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                dz_q, dz_d;
    logic                last_cycle;

    // Final settle edge: the divider outputs are valid and get captured.
    assign last_cycle = (state_q == S_SETTLE) && (cnt_q == CNT_W'(1));

    // State and datapath registers.
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            dividend_q <= '0;
            divisor_q  <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            dz_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            dividend_q <= dividend_d;
            divisor_q  <= divisor_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            dz_q       <= dz_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (start) state_d = S_SETTLE;
            S_SETTLE: if (last_cycle) state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Register next values for counter, operands, HI/LO and status.
    always_comb begin
        cnt_d      = cnt_q;
        dividend_d = dividend_q;
        divisor_d  = divisor_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        busy_d     = 1'b0;
        done_d     = 1'b0;
        dz_d       = dz_q;
        case (state_q)
            S_IDLE: begin
                // Moves apply first; a simultaneous divide overwrites later.
                if (hi_wr) hi_d = hi_in;
                if (lo_wr) lo_d = lo_in;
                if (start) begin
                    dividend_d = dividend_in;
                    divisor_d  = divisor_in;
                    cnt_d      = CNT_W'(SETTLE_CYCLES);
                    busy_d     = 1'b1;
                end
            end
            S_SETTLE: begin
                cnt_d  = cnt_q - CNT_W'(1);
                busy_d = !last_cycle;
                if (last_cycle) begin
                    done_d = 1'b1;
                    if (divisor_q == '0) begin
                        lo_d = '1;
                        hi_d = dividend_q;
                        dz_d = 1'b1;
                    end else begin
                        lo_d = div_quotient;
                        // Remainder follows the dividend's sign; zero stays zero.
                        hi_d = dividend_q[DATA_W-1] ? (DATA_W'(0) - div_remainder)
                                                    : div_remainder;
                        dz_d = 1'b0;
                    end
                end
            end
            default: begin
                cnt_d = '0;
            end
        endcase
    end

    assign div_dividend = dividend_q;
    assign div_divisor  = divisor_q;
    assign hi_out       = hi_q;
    assign lo_out       = lo_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign div_zero     = dz_q;

endmodule

// File: tb/tb_div_hilo_seq.sv
// Bench for div_hilo_seq: two instances (SETTLE_CYCLES 4 and 1) share stimulus;
// a remaining-cycles reference model is compared against both every cycle.
module tb_div_hilo_seq;

    localparam int unsigned N0 = 4;
    localparam int unsigned N1 = 1;

    logic        clock = 1'b0;
    logic        clear;
    logic        start;
    logic [31:0] dividend_in, divisor_in;
    logic        hi_wr, lo_wr;
    logic [31:0] hi_in, lo_in;

    logic [31:0] dd0, dv0, dq0, dr0, hi0, lo0;
    logic        busy0, done0, dz0;
    logic [31:0] dd1, dv1, dq1, dr1, hi1, lo1;
    logic        busy1, done1, dz1;

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 1'b0;

    // Reference model state per instance.
    logic [31:0] m_a[2], m_b[2], m_hi[2], m_lo[2];
    int          m_left[2];
    logic        m_done[2], m_dz[2];

    always #5 clock = ~clock;

    // Environment: the combinational divider (remainder as a magnitude).
    function automatic logic [31:0] drv_q(input logic [31:0] a, input logic [31:0] b);
        longint la, lb, q;
        if (b == 32'd0) return 32'hBAD0_BAD0;
        la = longint'($signed(a));
        lb = longint'($signed(b));
        q  = la / lb;
        return q[31:0];
    endfunction

    function automatic logic [31:0] drv_r(input logic [31:0] a, input logic [31:0] b);
        longint la, lb, r;
        if (b == 32'd0) return 32'h5A5A_5A5A;
        la = longint'($signed(a));
        lb = longint'($signed(b));
        if (la < 0) la = -la;
        if (lb < 0) lb = -lb;
        r = la % lb;
        return r[31:0];
    endfunction

    // Architectural results: truncating signed divide, remainder signed like dividend.
    function automatic logic [31:0] ref_lo(input logic [31:0] a, input logic [31:0] b);
        longint q;
        if (b == 32'd0) return 32'hFFFF_FFFF;
        q = longint'($signed(a)) / longint'($signed(b));
        return q[31:0];
    endfunction

    function automatic logic [31:0] ref_hi(input logic [31:0] a, input logic [31:0] b);
        longint r;
        if (b == 32'd0) return a;
        r = longint'($signed(a)) % longint'($signed(b));
        return r[31:0];
    endfunction

    assign dq0 = drv_q(dd0, dv0);
    assign dr0 = drv_r(dd0, dv0);
    assign dq1 = drv_q(dd1, dv1);
    assign dr1 = drv_r(dd1, dv1);

    div_hilo_seq #(.SETTLE_CYCLES(N0)) u_dut0 (
        .clock(clock), .clear(clear), .start(start),
        .dividend_in(dividend_in), .divisor_in(divisor_in),
        .hi_wr(hi_wr), .lo_wr(lo_wr), .hi_in(hi_in), .lo_in(lo_in),
        .div_dividend(dd0), .div_divisor(dv0),
        .div_quotient(dq0), .div_remainder(dr0),
        .busy(busy0), .done(done0), .div_zero(dz0),
        .hi_out(hi0), .lo_out(lo0)
    );

    div_hilo_seq #(.SETTLE_CYCLES(N1)) u_dut1 (
        .clock(clock), .clear(clear), .start(start),
        .dividend_in(dividend_in), .divisor_in(divisor_in),
        .hi_wr(hi_wr), .lo_wr(lo_wr), .hi_in(hi_in), .lo_in(lo_in),
        .div_dividend(dd1), .div_divisor(dv1),
        .div_quotient(dq1), .div_remainder(dr1),
        .busy(busy1), .done(done1), .div_zero(dz1),
        .hi_out(hi1), .lo_out(lo1)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a divide occupies N edges after capture; results land on the last.
    always @(posedge clock or posedge clear) begin
        for (int i = 0; i < 2; i++) begin
            if (clear) begin
                m_a[i] <= '0; m_b[i] <= '0; m_hi[i] <= '0; m_lo[i] <= '0;
                m_left[i] <= 0; m_done[i] <= 1'b0; m_dz[i] <= 1'b0;
            end else if (m_left[i] == 0) begin
                m_done[i] <= 1'b0;
                if (hi_wr) m_hi[i] <= hi_in;
                if (lo_wr) m_lo[i] <= lo_in;
                if (start) begin
                    m_a[i]    <= dividend_in;
                    m_b[i]    <= divisor_in;
                    m_left[i] <= (i == 0) ? int'(N0) : int'(N1);
                end
            end else begin
                m_left[i] <= m_left[i] - 1;
                m_done[i] <= (m_left[i] == 1);
                if (m_left[i] == 1) begin
                    m_lo[i] <= ref_lo(m_a[i], m_b[i]);
                    m_hi[i] <= ref_hi(m_a[i], m_b[i]);
                    m_dz[i] <= (m_b[i] == 32'd0);
                end
            end
        end
    end

    // Per-cycle comparison of both instances against the model.
    always @(negedge clock) begin
        if (chk_en) begin
            check("d0.busy", 32'(busy0), 32'(m_left[0] != 0));
            check("d0.done", 32'(done0), 32'(m_done[0]));
            check("d0.dz",   32'(dz0),   32'(m_dz[0]));
            check("d0.dd",   dd0, m_a[0]);
            check("d0.dv",   dv0, m_b[0]);
            check("d0.hi",   hi0, m_hi[0]);
            check("d0.lo",   lo0, m_lo[0]);
            check("d1.busy", 32'(busy1), 32'(m_left[1] != 0));
            check("d1.done", 32'(done1), 32'(m_done[1]));
            check("d1.dz",   32'(dz1),   32'(m_dz[1]));
            check("d1.dd",   dd1, m_a[1]);
            check("d1.dv",   dv1, m_b[1]);
            check("d1.hi",   hi1, m_hi[1]);
            check("d1.lo",   lo1, m_lo[1]);
        end
    end

    // Called at a negedge; returns at the negedge where instance 0 shows done.
    task automatic run_div(input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] elo, input logic [31:0] ehi, input logic edz);
        int n;
        int bc;
        start = 1'b1; dividend_in = a; divisor_in = b;
        @(negedge clock);
        start = 1'b0;
        n  = 1;
        bc = busy0 ? 1 : 0;
        while (!done0 && n < 20) begin
            @(negedge clock);
            n++;
            if (busy0) bc++;
        end
        check("lat_done", 32'(n), 32'(N0 + 1));
        check("busy_cycles", 32'(bc), 32'(N0));
        check("lit_lo", lo0, elo);
        check("lit_hi", hi0, ehi);
        check("lit_dz", 32'(dz0), 32'(edz));
        check("model_lo", m_lo[0], elo);
        check("model_hi", m_hi[0], ehi);
    endtask

    task automatic check_zero(input string tag);
        check({tag, ".dd"}, dd0, 32'd0);
        check({tag, ".dv"}, dv0, 32'd0);
        check({tag, ".hi"}, hi0, 32'd0);
        check({tag, ".lo"}, lo0, 32'd0);
        check({tag, ".busy"}, 32'(busy0), 32'd0);
        check({tag, ".done"}, 32'(done0), 32'd0);
        check({tag, ".dz"}, 32'(dz0), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int cnt;
        clear = 1'b0; start = 1'b0; hi_wr = 1'b0; lo_wr = 1'b0;
        dividend_in = '0; divisor_in = '0; hi_in = '0; lo_in = '0;
        #1 clear = 1'b1;
        #1 check_zero("reset");
        @(negedge clock);
        @(negedge clock);
        clear  = 1'b0;
        chk_en = 1'b1;

        // Signed, divide-by-zero and overflow cases, issued back-to-back.
        run_div(32'd100, 32'd7, 32'd14, 32'd2, 1'b0);
        run_div(-32'sd100, 32'd7, 32'hFFFF_FFF2, 32'hFFFF_FFFE, 1'b0);
        run_div(32'd100, -32'sd7, 32'hFFFF_FFF2, 32'd2, 1'b0);
        run_div(-32'sd100, -32'sd7, 32'd14, 32'hFFFF_FFFE, 1'b0);
        run_div(-32'sd14, 32'd7, 32'hFFFF_FFFE, 32'd0, 1'b0);
        run_div(32'h1234_5678, 32'd0, 32'hFFFF_FFFF, 32'h1234_5678, 1'b1);
        run_div(32'd9, 32'd3, 32'd3, 32'd0, 1'b0);
        run_div(32'd50, 32'd5, 32'd10, 32'd0, 1'b0);
        run_div(32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b0);
        @(negedge clock);

        // mthi/mtlo while idle.
        hi_wr = 1'b1; lo_wr = 1'b1; hi_in = 32'hCAFE_0001; lo_in = 32'hCAFE_0002;
        @(negedge clock);
        hi_wr = 1'b0; lo_wr = 1'b0;
        check("mthi", hi0, 32'hCAFE_0001);
        check("mtlo", lo0, 32'hCAFE_0002);

        // Second start and mthi during a divide are ignored.
        start = 1'b1; dividend_in = 32'd100; divisor_in = 32'd7;
        @(negedge clock);
        start = 1'b0;
        @(negedge clock);
        start = 1'b1; dividend_in = 32'd1; divisor_in = 32'd1;
        hi_wr = 1'b1; hi_in = 32'hDEAD_BEEF;
        @(negedge clock);
        start = 1'b0; hi_wr = 1'b0;
        check("busy_dd_held", dd0, 32'd100);
        check("busy_hi_held", hi0, 32'hCAFE_0001);
        n = 0;
        while (!done0 && n < 20) begin
            @(negedge clock);
            n++;
        end
        check("busy_lo", lo0, 32'd14);
        check("busy_hi", hi0, 32'd2);
        cnt = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clock);
            if (done0) cnt++;
        end
        check("single_done", 32'(cnt), 32'd0);

        // SETTLE_CYCLES=1: done on the edge right after the start edge.
        start = 1'b1; dividend_in = 32'd50; divisor_in = 32'd5;
        @(negedge clock);
        start = 1'b0;
        check("s1_not_yet", 32'(done1), 32'd0);
        @(negedge clock);
        check("s1_done", 32'(done1), 32'd1);
        check("s1_lo", lo1, 32'd10);
        check("s1_hi", hi1, 32'd0);
        for (int k = 0; k < 5; k++) @(negedge clock);

        // Asynchronous clear two cycles into a divide.
        start = 1'b1; dividend_in = 32'd77; divisor_in = 32'd5;
        @(negedge clock);
        start = 1'b0;
        @(negedge clock);
        #2 clear = 1'b1;
        #1 check_zero("clr");
        @(negedge clock);
        clear = 1'b0;
        cnt = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clock);
            if (done0) cnt++;
        end
        check("clr_no_done", 32'(cnt), 32'd0);
        run_div(-32'sd100, -32'sd7, 32'd14, 32'hFFFF_FFFE, 1'b0);
        @(negedge clock);

        // Randomized traffic, including one mid-stream clear.
        for (int it = 0; it < 400; it++) begin
            int sel;
            @(negedge clock);
            start = ($urandom_range(0, 2) == 0);
            hi_wr = ($urandom_range(0, 3) == 0);
            lo_wr = ($urandom_range(0, 3) == 0);
            hi_in = $urandom;
            lo_in = $urandom;
            sel = int'($urandom_range(0, 5));
            case (sel)
                0: begin dividend_in = $urandom; divisor_in = $urandom; end
                1: begin dividend_in = 32'($urandom_range(0, 400)) - 32'd200;
                         divisor_in  = 32'($urandom_range(0, 40)) - 32'd20; end
                2: begin dividend_in = $urandom; divisor_in = 32'd0; end
                3: begin dividend_in = 32'h8000_0000; divisor_in = 32'hFFFF_FFFF; end
                4: begin dividend_in = $urandom; divisor_in = 32'($urandom_range(1, 9)); end
                default: begin dividend_in = 32'($urandom_range(0, 50)) - 32'd25;
                               divisor_in  = $urandom; end
            endcase
            if (it == 200) begin
                #2 clear = 1'b1;
                @(negedge clock);
                clear = 1'b0;
            end
        end
        @(negedge clock);
        start = 1'b0; hi_wr = 1'b0; lo_wr = 1'b0;
        for (int k = 0; k < 10; k++) @(negedge clock);

        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
